// File: rtl/sfp_row_norm.sv
// sfp_row_norm
// ------------
// Row normalizer for the special function processor (SFP) path. It takes one
// psum row of `col` signed lanes and adds up the magnitudes of the lanes. It
// then divides every lane by (abs-sum >> SHIFT), truncating toward zero, and
// returns the normalized row on a valid/ready output for write-back.
//
// Processing sequence:
//   IDLE : accept a row, latch the per-lane magnitude and sign
//   SUM  : form the abs-sum, clear the quotient and remainder registers
//   DIV  : restoring radix-2 division, one quotient bit per cycle, MSB first,
//          all lanes in parallel against one shared divisor
//   FIX  : restore the lane signs and raise out_valid
//   OUT  : hold the result until out_ready
// A zero divisor skips DIV. Its quotients are forced to 0 and out_dz is
// raised.
//
// Ports:
//   clk        rising-edge clock
//   reset      synchronous, active-low reset
//   in_data    input row; lane i = in_data[bw_psum*(i+1)-1 : bw_psum*i]
//   in_valid   in_data valid
//   in_ready   high while IDLE (combinational)
//   out_data   normalized row, same lane order
//   out_valid  out_data valid
//   out_ready  consumer accepts out_data
//   out_dz     divisor was zero for this row (qualified by out_valid)
//   sum_out    full abs-sum of the row (only with SFP_NORM_SUM_OUT_EN)
//
// Optional feature macro: SFP_NORM_SUM_OUT_EN adds the sum_out port.
module sfp_row_norm #(
  parameter int bw_psum = 20,
  parameter int col     = 8,
  parameter int SHIFT   = 7
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [bw_psum*col-1:0]   in_data,
  input  logic                     in_valid,
  output logic                     in_ready,
  output logic [bw_psum*col-1:0]   out_data,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic                     out_dz
`ifdef SFP_NORM_SUM_OUT_EN
  ,
  output logic [bw_psum+3:0]       sum_out
`endif
);

  localparam int SW = bw_psum + 4;        // abs-sum width, safe for col <= 16
  localparam int CW = $clog2(bw_psum);    // iteration counter width

  typedef enum logic [2:0] {IDLE, SUM, DIV, FIX, OUT} state_t;

  state_t                   state_reg;
  logic [CW-1:0]            cnt_reg;
  logic [SW-1:0]            sum_reg;
  logic                     dz_reg;
  logic [col-1:0]           sign_reg;
  logic [bw_psum-1:0]       mag_reg [col];   // dividend, shifted out MSB first
  logic [bw_psum-1:0]       quo_reg [col];
  logic [SW-1:0]            rem_reg [col];
  logic [bw_psum*col-1:0]   out_data_reg;
  logic                     out_valid_reg;
  logic                     out_dz_reg;

  // The divisor keeps the full sum width. Its upper bits are constant zero,
  // and the extra width leaves no slice of the sum unused.
  logic [SW-1:0]            divisor;
  logic [SW-1:0]            sum_next;
  logic [bw_psum-1:0]       abs_in   [col];
  logic [SW-1:0]            rem_step [col];
  logic [col-1:0]           q_bit;
  logic [bw_psum-1:0]       fix_lane [col];

  assign divisor  = sum_reg >> SHIFT;
  assign in_ready = (state_reg == IDLE);

  always_comb begin
    sum_next = '0;
    for (int i = 0; i < col; i++) begin
      sum_next = sum_next + SW'(mag_reg[i]);
    end
  end

  generate
    for (genvar gi = 0; gi < col; gi++) begin : g_lane
      logic [bw_psum-1:0] lane_raw;
      logic [SW:0]        trial;

      assign lane_raw = in_data[gi*bw_psum +: bw_psum];
      // Unsigned magnitude, so the most negative value maps to 2^(bw_psum-1).
      assign abs_in[gi] = lane_raw[bw_psum-1] ? (~lane_raw + bw_psum'(1)) : lane_raw;

      // One restoring step: bring in the next dividend bit, then subtract
      // if it fits. The remainder stays below the divisor, so the
      // subtraction result always fits SW bits.
      assign trial        = {rem_reg[gi], mag_reg[gi][bw_psum-1]};
      assign q_bit[gi]    = (trial >= {1'b0, divisor});
      assign rem_step[gi] = q_bit[gi] ? (trial[SW-1:0] - divisor) : trial[SW-1:0];

      // The quotient magnitude never exceeds |x|, so negation cannot overflow.
      assign fix_lane[gi] = sign_reg[gi] ? (-quo_reg[gi]) : quo_reg[gi];
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_reg     <= IDLE;
      cnt_reg       <= '0;
      sum_reg       <= '0;
      dz_reg        <= 1'b0;
      sign_reg      <= '0;
      out_data_reg  <= '0;
      out_valid_reg <= 1'b0;
      out_dz_reg    <= 1'b0;
      for (int i = 0; i < col; i++) begin
        mag_reg[i] <= '0;
        quo_reg[i] <= '0;
        rem_reg[i] <= '0;
      end
    end else begin
      case (state_reg)
        IDLE: begin
          if (in_valid) begin
            for (int i = 0; i < col; i++) begin
              mag_reg[i]  <= abs_in[i];
              sign_reg[i] <= in_data[i*bw_psum + bw_psum - 1];
            end
            state_reg <= SUM;
          end
        end

        SUM: begin
          sum_reg <= sum_next;
          dz_reg  <= 1'b0;
          cnt_reg <= '0;
          for (int i = 0; i < col; i++) begin
            quo_reg[i] <= '0;
            rem_reg[i] <= '0;
          end
          state_reg <= DIV;
        end

        DIV: begin
          if (divisor == '0) begin
            dz_reg <= 1'b1;
            for (int i = 0; i < col; i++) begin
              quo_reg[i] <= '0;
            end
            state_reg <= FIX;
          end else begin
            for (int i = 0; i < col; i++) begin
              rem_reg[i] <= rem_step[i];
              quo_reg[i] <= {quo_reg[i][bw_psum-2:0], q_bit[i]};
              mag_reg[i] <= mag_reg[i] << 1;
            end
            if (cnt_reg == CW'(bw_psum - 1)) begin
              cnt_reg   <= '0;
              state_reg <= FIX;
            end else begin
              cnt_reg <= cnt_reg + CW'(1);
            end
          end
        end

        FIX: begin
          for (int i = 0; i < col; i++) begin
            out_data_reg[i*bw_psum +: bw_psum] <= fix_lane[i];
          end
          out_dz_reg    <= dz_reg;
          out_valid_reg <= 1'b1;
          state_reg     <= OUT;
        end

        OUT: begin
          if (out_ready) begin
            out_valid_reg <= 1'b0;
            state_reg     <= IDLE;
          end
        end

        default: state_reg <= IDLE;
      endcase
    end
  end

  assign out_data  = out_data_reg;
  assign out_valid = out_valid_reg;
  assign out_dz    = out_dz_reg;

`ifdef SFP_NORM_SUM_OUT_EN
  // sum_reg is written only in SUM, so it stays valid through OUT.
  assign sum_out = sum_reg;
`endif

endmodule

// File: tb/tb_sfp_row_norm.sv
// tb_sfp_row_norm
// ---------------
// Directed testbench for sfp_row_norm. A table holds the input rows and the
// expected normalized rows; each row is run through the block in a loop.
// Separate sequences cover output backpressure with a second row held
// upstream, and a reset that arrives during the division.
module tb_sfp_row_norm;

  localparam int BW   = 20;
  localparam int COLS = 8;
  localparam int W    = BW * COLS;

  logic           clk;
  logic           reset;
  logic [W-1:0]   in_data;
  logic           in_valid;
  logic           in_ready;
  logic [W-1:0]   out_data;
  logic           out_valid;
  logic           out_ready;
  logic           out_dz;
`ifdef SFP_NORM_SUM_OUT_EN
  logic [BW+3:0]  sum_out;
`endif

  int total;
  int bad;

  sfp_row_norm #(.bw_psum(BW), .col(COLS), .SHIFT(7)) dut (
    .clk       (clk),
    .reset     (reset),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_dz    (out_dz)
`ifdef SFP_NORM_SUM_OUT_EN
    ,
    .sum_out   (sum_out)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [W-1:0] din;
    logic [W-1:0] dexp;
    logic         dz;
    int           lat;
  } vec_t;

  vec_t tbl [8];

  function automatic logic [W-1:0] pack8(input int a0, input int a1, input int a2, input int a3,
                                         input int a4, input int a5, input int a6, input int a7);
    logic [W-1:0] v;
    v[0*BW +: BW] = a0[BW-1:0];
    v[1*BW +: BW] = a1[BW-1:0];
    v[2*BW +: BW] = a2[BW-1:0];
    v[3*BW +: BW] = a3[BW-1:0];
    v[4*BW +: BW] = a4[BW-1:0];
    v[5*BW +: BW] = a5[BW-1:0];
    v[6*BW +: BW] = a6[BW-1:0];
    v[7*BW +: BW] = a7[BW-1:0];
    return v;
  endfunction

  task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %h required %h", name, act, req);
    end
  endtask

  // Waits for the output, then checks latency, data and dz, and completes
  // the handshake. The start point is the falling edge after the accept edge.
  task automatic finish_row(input string tag, input logic [W-1:0] dexp, input logic dz, input int lat);
    int k;
    k = 0;
    while (!out_valid && k < 100) begin
      @(negedge clk);
      k++;
    end
    chk({tag, " latency"}, W'(k), W'(lat));
    chk({tag, " data"}, out_data, dexp);
    chk({tag, " dz"}, W'(out_dz), W'(dz));
    $display("%s: out=%h dz=%0d latency=%0d", tag, out_data, out_dz, k);
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    chk({tag, " valid_drop"}, W'(out_valid), W'(0));
    chk({tag, " ready_back"}, W'(in_ready), W'(1));
  endtask

  task automatic start_row(input string tag, input logic [W-1:0] din);
    int k;
    k = 0;
    while (!in_ready && k < 50) begin
      @(negedge clk);
      k++;
    end
    if (!in_ready) begin
      total++;
      bad++;
      $display("FAIL %s in_ready_wait: got 0 required 1", tag);
    end
    in_data  = din;
    in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    in_data  = '0;
  endtask

  initial begin
    total = 0;
    bad   = 0;
    reset     = 1'b0;
    in_data   = '0;
    in_valid  = 1'b0;
    out_ready = 1'b0;

    tbl[0] = '{pack8(256, 256, 256, 256, 256, 256, 256, 256),
               pack8(16, 16, 16, 16, 16, 16, 16, 16), 1'b0, 22};
    tbl[1] = '{pack8(-512, 512, 0, 0, 0, 0, 0, 0),
               pack8(-64, 64, 0, 0, 0, 0, 0, 0), 1'b0, 22};
    tbl[2] = '{pack8(-1000, 24, 24, 24, 24, 24, 24, 24),
               pack8(-111, 2, 2, 2, 2, 2, 2, 2), 1'b0, 22};
    tbl[3] = '{pack8(10, 10, 10, 10, 10, 10, 10, 10),
               pack8(0, 0, 0, 0, 0, 0, 0, 0), 1'b1, 3};
    tbl[4] = '{pack8(1000, -2000, 3000, -4000, 5000, -6000, 7000, -8000),
               pack8(3, -7, 10, -14, 17, -21, 24, -28), 1'b0, 22};
    tbl[5] = '{pack8(-524288, 0, 0, 0, 0, 0, 0, 0),
               pack8(-128, 0, 0, 0, 0, 0, 0, 0), 1'b0, 22};
    tbl[6] = '{pack8(100, 28, 0, 0, 0, 0, 0, 0),
               pack8(100, 28, 0, 0, 0, 0, 0, 0), 1'b0, 22};
    tbl[7] = '{pack8(-127, 0, 0, 0, 0, 0, 0, 0),
               pack8(0, 0, 0, 0, 0, 0, 0, 0), 1'b1, 3};

    // Reset state
    repeat (3) @(negedge clk);
    chk("reset out_valid", W'(out_valid), W'(0));
    chk("reset out_data", out_data, '0);
    chk("reset out_dz", W'(out_dz), W'(0));
    reset = 1'b1;
    @(negedge clk);
    chk("reset in_ready", W'(in_ready), W'(1));

    // Table-driven rows
    for (int r = 0; r < 8; r++) begin
      string tag;
      tag = $sformatf("row%0d", r);
      start_row(tag, tbl[r].din);
      finish_row(tag, tbl[r].dexp, tbl[r].dz, tbl[r].lat);
    end

    // Backpressure, with a second row held upstream while the block is busy
    begin
      int k;
      start_row("bp_a", tbl[0].din);
      in_data  = tbl[4].din;
      in_valid = 1'b1;
      k = 0;
      while (!out_valid && k < 100) begin
        @(negedge clk);
        k++;
        if (k == 10) chk("bp busy in_ready", W'(in_ready), W'(0));
      end
      chk("bp_a latency", W'(k), W'(22));
      chk("bp_a data", out_data, tbl[0].dexp);
      for (int c = 0; c < 5; c++) begin
        @(negedge clk);
        chk($sformatf("bp hold%0d valid", c), W'(out_valid), W'(1));
        chk($sformatf("bp hold%0d data", c), out_data, tbl[0].dexp);
        chk($sformatf("bp hold%0d in_ready", c), W'(in_ready), W'(0));
      end
      $display("bp_a: out=%h held 5 cycles", out_data);
      out_ready = 1'b1;
      @(negedge clk);
      out_ready = 1'b0;
      chk("bp_a valid_drop", W'(out_valid), W'(0));
      chk("bp in_ready after handshake", W'(in_ready), W'(1));
      // The held row B is taken on the next edge.
      @(negedge clk);
      in_valid = 1'b0;
      in_data  = '0;
      chk("bp_b accepted", W'(in_ready), W'(0));
      finish_row("bp_b", tbl[4].dexp, 1'b0, 22);
    end

    // Reset while the division is running
    start_row("rst_abort", tbl[2].din);
    repeat (8) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    chk("abort out_valid", W'(out_valid), W'(0));
    chk("abort in_ready", W'(in_ready), W'(1));
    chk("abort out_data", out_data, '0);
    reset = 1'b1;
    $display("rst_abort: row discarded by reset during division");
    start_row("post_rst", tbl[1].din);
    finish_row("post_rst", tbl[1].dexp, 1'b0, 22);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: got running required finished");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/sfp_row_norm.md
Name: sfp_row_norm

Overview:
- Row normalizer for the special function processor (SFP) path.
- Consumes one psum row (col lanes of bw_psum signed values) as read from psum memory.
- Accumulates the absolute-value sum of the row, then divides every lane by that sum right-shifted by SHIFT, truncating toward zero.
- The normalized row is returned on a valid/ready output for write-back to psum memory.

Parameters:
- bw_psum, 20, signed lane width (in and out).
- col, 8, lanes per row.
- SHIFT, 7, right shift applied to the abs-sum to form the divisor.

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  synchronous, active-low reset (asserted when 0, sampled on rising clk).
- in_data  input  bw_psum*col  psum row; lane i = in_data[bw_psum*(i+1)-1 : bw_psum*i].
- in_valid  input  1  in_data valid.
- in_ready  output  1  block can accept a row.
- out_data  output  bw_psum*col  normalized row, same lane order.
- out_valid  output  1  out_data valid.
- out_ready  input  1  consumer accepts out_data.
- out_dz  output  1  divisor was zero for this row; qualified by out_valid.

Behaviour:
- States: IDLE, SUM, DIV, FIX, OUT. Reset forces IDLE; reset mid-operation discards the row in flight.
- Reset values: out_valid=0, out_data=0, out_dz=0, iteration counter=0, accumulators=0.
- in_ready = (state==IDLE), combinational, so it reads 1 in the cycle after reset.
- IDLE: on in_valid & in_ready at edge E0:
  - latch per-lane magnitude |x| (bw_psum-bit unsigned; -2^(bw_psum-1) maps to 2^(bw_psum-1)) and lane sign;
  - go to SUM.
- SUM (edge E1):
  - sum = Σ|x| over col lanes, width bw_psum+4, zero-extended adds, no overflow for col≤16;
  - divisor = sum[bw_psum+3:SHIFT];
  - clear quotient/remainder registers; go to DIV.
- DIV: restoring radix-2 division, all col lanes in parallel, shared divisor.
  - One quotient bit per edge, MSB first; bw_psum edges (E2..E(bw_psum+1)).
  - Counter counts 0..bw_psum-1; go to FIX on the last iteration.
  - If divisor==0: skip DIV; quotients forced to 0 and dz latched 1; go to FIX at E2.
- FIX (one edge):
  - out lane = sign ? -q : q (two's complement, bw_psum bits);
  - out_dz = dz;
  - out_valid<=1; go to OUT.
- Latency (divisor≠0): out_valid high after edge E(bw_psum+2), i.e. 22 cycles for defaults. For divisor=0: after E3.
- OUT:
  - hold out_data/out_dz stable while out_valid & !out_ready;
  - on out_ready: out_valid<=0, go to IDLE; next row accepted no earlier than the following edge.
- in_valid while not IDLE: ignored; the row is not captured and the upstream holds it.
- Quotient magnitude ≤ |x|, so it always fits bw_psum bits; no saturation needed.
- Zero lane gives output 0 with no sign (never -0 issues in two's complement).

Optional Feature:
- Macro: SFP_NORM_SUM_OUT_EN.
- When defined: adds output port sum_out (bw_psum+4 bits), the full abs-sum of the current row.
  - Registered at SUM, held through OUT, valid with out_valid.
  - Reset value 0.
- When undefined: port absent; sum register internal only; no other change.

Test Plan:
- All 8 lanes +256 → sum 2048, divisor 16, every out lane 0x00010, out_dz=0, out_valid 22 cycles after accept.
- Lanes {-512, +512, 0×6} → sum 1024, divisor 8, lane0 0xFFFC0 (-64), lane1 0x00040, others 0.
- Lane0=-1000, lanes1–7=24 → sum 1168, divisor 9, lane0 -111 (0xFFF91), others 2 (truncation toward zero).
- All lanes 10 → sum 80, divisor 0 → out lanes 0, out_dz=1, out_valid 3 cycles after accept.
- Backpressure: out_ready=0 for 5 cycles; a second row is presented during busy.
  - out_data stable, out_valid held, in_ready=0, second row not captured.
  - After the handshake, the second row is accepted and processed correctly.
- reset=0 for one edge during DIV → out_valid=0, in_ready=1 next cycle; a fresh row then gives the correct result with no residue from the aborted row.
